// File: rtl/rom_if_pkg.sv
// Shared definitions for the one-hot-addressed ROM reader.
//   ROM_DEPTH / ROM_DATA_W : default ROM geometry
//   scan_state_t           : scan FSM state encoding
//   onehot()               : index -> one-hot address vector
package rom_if_pkg;

   localparam int unsigned ROM_DEPTH  = 8;
   localparam int unsigned ROM_DATA_W = 8;
   localparam int unsigned ROM_IDX_W  = $clog2(ROM_DEPTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      OUT   = 3'd3,
      DONE  = 3'd4
   } scan_state_t;

   // One-hot address for a ROM word index
   function automatic logic [ROM_DEPTH-1:0] onehot(input logic [ROM_IDX_W-1:0] idx);
      onehot = ROM_DEPTH'(1) << idx;
   endfunction

endpackage

// File: rtl/rom_scan_reader_if.sv
// ROM read port plus the captured-word valid/ready stream.
//   rom_enable, rom_address, rom_data : ROM controller side
//   out_data, out_idx, out_valid, out_ready : downstream stream
// master = the scan reader, slave = ROM model / consumer.
interface rom_scan_reader_if
   import rom_if_pkg::*;
#(
   parameter int unsigned DEPTH  = ROM_DEPTH,
   parameter int unsigned DATA_W = ROM_DATA_W,
   parameter int unsigned IDX_W  = $clog2(DEPTH)
);

   logic              rom_enable;
   logic [DEPTH-1:0]  rom_address;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output rom_enable,
      output rom_address,
      input  rom_data,
      output out_data,
      output out_idx,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  rom_enable,
      input  rom_address,
      output rom_data,
      input  out_data,
      input  out_idx,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/rom_scan_reader.sv
// Scans every ROM word 0..DEPTH-1 on a start pulse: issues a one-hot read,
// waits RD_LAT clocks, captures the word and offers it on a valid/ready
// stream while keeping a running checksum of accepted words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle scan request, dropped unless idle
//   bus        : ROM read port and output stream (master side)
//   busy       : scan in progress (ISSUE/WAIT/OUT)
//   done       : one-cycle pulse after the last word is accepted
//   checksum   : sum mod 2^DATA_W of words accepted in this scan
module rom_scan_reader
   import rom_if_pkg::*;
#(
   parameter int unsigned DEPTH  = ROM_DEPTH,
   parameter int unsigned DATA_W = ROM_DATA_W,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   rom_scan_reader_if.master bus,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   // lat_cnt only has to hold RD_LAT-1
   localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   scan_state_t       state, state_d;
   logic [IDX_W-1:0]  idx, idx_d;
   logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;

   logic              rom_enable_q, rom_enable_d;
   logic [DEPTH-1:0]  rom_address_q, rom_address_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0]  out_idx_q, out_idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] checksum_q, checksum_d;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         lat_cnt       <= '0;
         rom_enable_q  <= 1'b0;
         rom_address_q <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_idx_q     <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         checksum_q    <= '0;
      end else begin
         state         <= state_d;
         idx           <= idx_d;
         lat_cnt       <= lat_cnt_d;
         rom_enable_q  <= rom_enable_d;
         rom_address_q <= rom_address_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_idx_q     <= out_idx_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         checksum_q    <= checksum_d;
      end
   end

   // Next state; outputs are decoded from the next state so they register
   // into place in the same cycle the FSM enters that state.
   always_comb begin
      state_d    = state;
      idx_d      = idx;
      lat_cnt_d  = lat_cnt;
      out_data_d = out_data_q;
      out_idx_d  = out_idx_q;
      checksum_d = checksum_q;

      case (state)
         IDLE: begin
            if (start) begin
               state_d    = ISSUE;
               idx_d      = '0;
               checksum_d = '0;
            end
         end
         ISSUE: begin
            state_d   = WAIT;
            lat_cnt_d = LAT_W'(RD_LAT - 1);
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               out_data_d = bus.rom_data;
               out_idx_d  = idx;
               state_d    = OUT;
            end else begin
               lat_cnt_d = lat_cnt - LAT_W'(1);
            end
         end
         OUT: begin
            // out_valid is always high here, so out_ready alone is the handshake
            if (bus.out_ready) begin
               checksum_d = checksum_q + out_data_q;
               if (idx == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx + IDX_W'(1);
                  state_d = ISSUE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      rom_enable_d  = (state_d == ISSUE) || (state_d == WAIT);
      rom_address_d = rom_enable_d ? (DEPTH'(1) << idx_d) : '0;
      out_valid_d   = (state_d == OUT);
      busy_d        = rom_enable_d || out_valid_d;
      done_d        = (state_d == DONE);
   end

   assign bus.rom_enable  = rom_enable_q;
   assign bus.rom_address = rom_address_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_idx     = out_idx_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign checksum        = checksum_q;

   // Structural invariants of the read port and stream
   a_addr_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      rom_enable_q |-> $onehot(rom_address_q));

   a_valid_in_out: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid_q |-> (state == OUT));

   a_no_read_while_valid: assert property (@(posedge clk) disable iff (!rst_n)
      !(out_valid_q && rom_enable_q));

   a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid_q && !bus.out_ready) |=>
         (out_valid_q && $stable(out_data_q) && $stable(out_idx_q)));

endmodule
